// File: rtl/prog_mem_loader.sv
// Program memory with a byte-stream upgrade loader; CPU reads are blocked while loading.
// Optional build macro PRGMEM_CHKSUM_EN adds a trailing checksum byte and the sticky ld_err_o flag.
module prog_mem_loader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_vld_o,
  input  logic              ld_start_i,
  input  logic [ADDR_W:0]   ld_len_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_byte_vld_i,
  output logic              ld_busy_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic [ADDR_W:0]   ld_wcnt_o,
  output logic [1:0]        ld_state_o
);

  localparam int BPW   = DATA_W / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [ADDR_W:0]  DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef PRGMEM_CHKSUM_EN
  localparam logic [1:0] S_CHK  = 2'd2;
  localparam logic [1:0] S_EXIT = S_CHK;
`else
  localparam logic [1:0] S_EXIT = S_DONE;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        state_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] full_word;
  logic              wr_en;
  logic              busy;

  // Byte stream has no back-pressure: a byte is consumed on every cycle
  // ld_byte_vld_i is high while loading (LOAD, or CHK for the check byte);
  // bytes presented in any other state are dropped.
  always_comb begin
    full_word = word_q;
    full_word[idx_q*8 +: 8] = ld_byte_i;
  end

  assign busy  = (state_q == S_LOAD) || (state_q == S_EXIT && S_EXIT != S_DONE);
  assign wr_en = (state_q == S_LOAD) && (wcnt_q != len_q) && ld_byte_vld_i && (idx_q == LAST_IDX);

  // Memory has no reset so a reset mid-load keeps the words already written.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wcnt_q[ADDR_W-1:0]] <= full_word;
  end

`ifdef PRGMEM_CHKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else if ((state_q == S_IDLE || state_q == S_DONE) && ld_start_i) begin
      sum_q <= 8'd0;
      err_q <= 1'b0;
    end else if (state_q == S_LOAD && wcnt_q != len_q && ld_byte_vld_i) begin
      sum_q <= sum_q + ld_byte_i;
    end else if (state_q == S_CHK && ld_byte_vld_i) begin
      if (8'(sum_q + ld_byte_i) != 8'd0) err_q <= 1'b1;
    end
  end

  assign ld_err_o = err_q;
`else
  assign ld_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ld_start_i) begin
            state_q <= S_LOAD;
            len_q   <= (ld_len_i > DEPTH_W) ? DEPTH_W : ld_len_i;
            wcnt_q  <= '0;
            idx_q   <= '0;
          end
        end
        S_LOAD: begin
          if (wcnt_q == len_q) begin
            state_q <= S_EXIT;
          end else if (ld_byte_vld_i) begin
            word_q <= full_word;
            if (idx_q == LAST_IDX) begin
              idx_q  <= '0;
              wcnt_q <= wcnt_q + (ADDR_W+1)'(1);
              if (wcnt_q + (ADDR_W+1)'(1) == len_q) state_q <= S_EXIT;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
`ifdef PRGMEM_CHKSUM_EN
        S_CHK: begin
          if (ld_byte_vld_i) state_q <= S_DONE;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_o     <= '0;
      instr_vld_o <= 1'b0;
    end else if (rd_en_i) begin
      if (busy) begin
        instr_o     <= '0;
        instr_vld_o <= 1'b0;
      end else if ({1'b0, adr_i} >= DEPTH_W) begin
        instr_o     <= '0;
        instr_vld_o <= 1'b1;
      end else begin
        instr_o     <= mem[adr_i];
        instr_vld_o <= 1'b1;
      end
    end else begin
      instr_vld_o <= 1'b0;
    end
  end

  assign ld_busy_o  = busy;
  assign ld_done_o  = (state_q == S_DONE);
  assign ld_wcnt_o  = wcnt_q;
  assign ld_state_o = state_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed cases plus randomized loads/reads
// against a byte-queue reference model. Checksum cases are built when PRGMEM_CHKSUM_EN is defined.
module tb_prog_mem_loader;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 48;
  localparam int BPW    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] adr = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] instr;
  logic              instr_vld;
  logic              ld_start = 1'b0;
  logic [ADDR_W:0]   ld_len = '0;
  logic [7:0]        ld_byte = '0;
  logic              ld_byte_vld = 1'b0;
  logic              ld_busy, ld_done, ld_err;
  logic [ADDR_W:0]   ld_wcnt;
  logic [1:0]        ld_state;

  prog_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .adr_i(adr), .rd_en_i(rd_en),
    .instr_o(instr), .instr_vld_o(instr_vld),
    .ld_start_i(ld_start), .ld_len_i(ld_len), .ld_byte_i(ld_byte), .ld_byte_vld_i(ld_byte_vld),
    .ld_busy_o(ld_busy), .ld_done_o(ld_done), .ld_err_o(ld_err), .ld_wcnt_o(ld_wcnt),
    .ld_state_o(ld_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: words are packed from the accepted byte stream.
  logic [31:0] model_mem [DEPTH];
  bit          model_ok  [DEPTH];
  logic [7:0]  part_q [$];
  logic [7:0]  model_sum;
  int          model_wcnt;
  int          model_len;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(int a);
    if (a >= DEPTH) return 32'h0;
    return model_mem[a];
  endfunction

  task automatic model_byte(logic [7:0] b);
    logic [31:0] w;
    if (model_wcnt >= model_len) return;
    model_sum = model_sum + b;
    part_q.push_back(b);
    if (part_q.size() == BPW) begin
      w = 32'h0;
      for (int i = 0; i < BPW; i++) w = w | (32'(part_q[i]) << (8 * i));
      model_mem[model_wcnt] = w;
      model_ok[model_wcnt]  = 1'b1;
      model_wcnt++;
      part_q.delete();
    end
  endtask

  task automatic send_raw(logic [7:0] b);
    repeat ($urandom_range(0, 2)) tick();
    ld_byte     = b;
    ld_byte_vld = 1'b1;
    tick();
    ld_byte_vld = 1'b0;
  endtask

  task automatic send_byte(logic [7:0] b);
    send_raw(b);
    model_byte(b);
  endtask

  // A byte driven alongside ld_start must be ignored by the loader.
  task automatic start_load(int len);
    ld_start    = 1'b1;
    ld_len      = (ADDR_W+1)'(len);
    ld_byte     = 8'($urandom);
    ld_byte_vld = 1'($urandom_range(0, 1));
    tick();
    ld_start    = 1'b0;
    ld_byte_vld = 1'b0;
    model_len   = (len > DEPTH) ? DEPTH : len;
    model_wcnt  = 0;
    model_sum   = 8'h0;
    part_q.delete();
  endtask

  task automatic wait_done(string tag, int budget);
    int n;
    n = 0;
    while (!ld_done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, 32'(ld_done), 32'h1);
  endtask

  task automatic finish_load(string tag, bit bad);
`ifdef PRGMEM_CHKSUM_EN
    logic [7:0] cb;
    if (model_len == 0) tick();
    check({tag, "_busy_chk"}, 32'(ld_busy), 32'h1);
    cb = 8'(8'h00 - model_sum) ^ (bad ? 8'h01 : 8'h00);
    send_raw(cb);
    wait_done(tag, 4);
    check({tag, "_err"}, 32'(ld_err), 32'(bad));
`else
    wait_done(tag, 4);
    check({tag, "_err"}, 32'(ld_err), 32'h0);
`endif
    check({tag, "_wcnt"}, 32'(ld_wcnt), 32'(model_len));
    check({tag, "_busy"}, 32'(ld_busy), 32'h0);
  endtask

  task automatic do_read(string tag, int a, logic [31:0] exp_d, logic exp_v);
    adr   = ADDR_W'(a);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check({tag, "_data"}, instr, exp_d);
    check({tag, "_vld"}, 32'(instr_vld), 32'(exp_v));
  endtask

  logic [7:0] dir_bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, len;
    tick();
    tick();
    rst = 1'b0;
    check("rst_instr", instr, 32'h0);
    check("rst_vld", 32'(instr_vld), 32'h0);
    check("rst_busy", 32'(ld_busy), 32'h0);
    check("rst_done", 32'(ld_done), 32'h0);
    check("rst_err", 32'(ld_err), 32'h0);
    check("rst_wcnt", 32'(ld_wcnt), 32'h0);

    // Directed two-word load and readback
    start_load(2);
    check("d_busy", 32'(ld_busy), 32'h1);
    for (int i = 0; i < 8; i++) send_byte(dir_bytes[i]);
    finish_load("d_load", 1'b0);
    do_read("d_rd1", 1, 32'hDEADBEEF, 1'b1);
    tick();
    check("hold_vld", 32'(instr_vld), 32'h0);
    check("hold_data", instr, 32'hDEADBEEF);
    do_read("d_rd0", 0, 32'h12345678, 1'b1);

    // Read blocked during load, then reset after six bytes
    start_load(2);
    do_read("busy_rd", 1, 32'h0, 1'b0);
    check("busy_flag", 32'(ld_busy), 32'h1);
    for (int i = 0; i < 6; i++) send_byte(dir_bytes[i]);
    check("mid_wcnt", 32'(ld_wcnt), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_wcnt", 32'(ld_wcnt), 32'h0);
    check("mrst_busy", 32'(ld_busy), 32'h0);
    check("mrst_done", 32'(ld_done), 32'h0);
    do_read("mrst_rd0", 0, 32'h12345678, 1'b1);
    do_read("mrst_rd1", 1, 32'hDEADBEEF, 1'b1);

    // Zero-length load
    start_load(0);
    finish_load("len0", 1'b0);
    send_raw(8'hAA);
    check("stray_wcnt", 32'(ld_wcnt), 32'h0);
    check("stray_done", 32'(ld_done), 32'h1);

`ifdef PRGMEM_CHKSUM_EN
    start_load(1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_raw(8'hF6);
    wait_done("ck_ok", 4);
    check("ck_ok_err", 32'(ld_err), 32'h0);
    start_load(1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    send_raw(8'hF5);
    wait_done("ck_bad", 4);
    check("ck_bad_err", 32'(ld_err), 32'h1);
`endif

    // Randomized loads and reads
    for (int it = 0; it < 6; it++) begin
      len = $urandom_range(1, 8);
      start_load(len);
      for (int i = 0; i < len * BPW; i++) send_byte(8'($urandom));
      finish_load("rnd_load", 1'($urandom_range(0, 3) == 0));
      for (int r = 0; r < 8; r++) begin
        a = $urandom_range(0, 63);
        if (a < DEPTH && !model_ok[a]) a = 0;
        do_read("rnd_rd", a, model_rd(a), 1'b1);
      end
    end

    // Length clamped to DEPTH; a start pulse mid-load is ignored
    start_load(60);
    for (int i = 0; i < DEPTH * BPW; i++) begin
      send_byte(8'($urandom));
      if (i == 10) begin
        ld_start = 1'b1;
        ld_len   = (ADDR_W+1)'(1);
        tick();
        ld_start = 1'b0;
        check("restart_busy", 32'(ld_busy), 32'h1);
      end
    end
    finish_load("clamp", 1'b0);
    do_read("clamp_rd47", 47, model_rd(47), 1'b1);
    do_read("oor_rd48", 48, 32'h0, 1'b1);
    do_read("oor_rd63", 63, 32'h0, 1'b1);
    do_read("clamp_rd5", 5, model_rd(5), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
